// File: rtl/ans_decoder.sv
// rANS decoder: loads the coder state from the chunk stream, recovers symbols
// through an external slot->symbol frequency table and renormalises from more chunks.
module ans_decoder #(
   parameter int SYM_WIDTH   = 8,
   parameter int CNT_WIDTH   = 9,
   parameter int PROB_BITS   = 8,
   parameter int STATE_WIDTH = 16,
   parameter int LEN_WIDTH   = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 ena_i,
   input  logic                 start_i,
   input  logic [LEN_WIDTH-1:0] num_syms_i,
   input  logic [SYM_WIDTH-1:0] in_data_i,
   input  logic                 in_vld_i,
   output logic                 in_rdy_o,
   output logic [PROB_BITS-1:0] lut_slot_o,
   input  logic [SYM_WIDTH-1:0] lut_sym_i,
   input  logic [CNT_WIDTH-1:0] lut_count_i,
   input  logic [CNT_WIDTH-1:0] lut_cum_i,
   output logic [SYM_WIDTH-1:0] out_o,
   output logic                 out_vld_o,
   input  logic                 out_rdy_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
);

   localparam int NCHUNK = STATE_WIDTH / SYM_WIDTH;
   localparam int CCW    = $clog2(NCHUNK) + 1;
   localparam logic [STATE_WIDTH-1:0] LBOUND = STATE_WIDTH'(1) << (STATE_WIDTH - SYM_WIDTH);
   localparam logic [CNT_WIDTH:0]     TOTAL  = (CNT_WIDTH + 1)'(1) << PROB_BITS;

   typedef enum logic [2:0] {IDLE, INIT, DECODE, OUTPUT, RENORM} fsmState_t;

   fsmState_t              fsm_q, fsm_d;
   logic [STATE_WIDTH-1:0] ans_q, ans_d;
   logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
   logic [CCW-1:0]         chunkCnt_q, chunkCnt_d;
   logic [SYM_WIDTH-1:0]   outSym_q, outSym_d;
   logic                   outVld_q, outVld_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic                   inRdy;
   logic [STATE_WIDTH-1:0] shifted;
   logic [STATE_WIDTH-1:0] decNext;
   logic [CNT_WIDTH:0]     cumEnd;
   logic                   lutBad;

   assign inRdy   = (fsm_q == INIT) || ((fsm_q == RENORM) && (ans_q < LBOUND));
   assign shifted = (ans_q << SYM_WIDTH) | STATE_WIDTH'(in_data_i);

   // Modular arithmetic: the wrap at STATE_WIDTH bits is the intended truncation.
   assign decNext = STATE_WIDTH'(lut_count_i) * (ans_q >> PROB_BITS)
                  + STATE_WIDTH'(ans_q[PROB_BITS-1:0])
                  - STATE_WIDTH'(lut_cum_i);
   assign cumEnd  = {1'b0, lut_cum_i} + {1'b0, lut_count_i};
   assign lutBad  = (lut_count_i == '0) || (cumEnd > TOTAL);

   always_comb begin
      fsm_d       = fsm_q;
      ans_d       = ans_q;
      remaining_d = remaining_q;
      chunkCnt_d  = chunkCnt_q;
      outSym_d    = outSym_q;
      outVld_d    = outVld_q;
      done_d      = 1'b0;
      err_d       = err_q;
      case (fsm_q)
         IDLE: begin
            if (start_i) begin
               err_d       = 1'b0;
               remaining_d = num_syms_i;
               chunkCnt_d  = '0;
               if (num_syms_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  fsm_d = INIT;
               end
            end
         end
         INIT: begin
            if (in_vld_i) begin
               ans_d      = shifted;
               chunkCnt_d = chunkCnt_q + CCW'(1);
               if (chunkCnt_q == CCW'(NCHUNK - 1)) begin
                  fsm_d = DECODE;
               end
            end
         end
         DECODE: begin
            if (lutBad) begin
               err_d  = 1'b1;
               done_d = 1'b1;
               fsm_d  = IDLE;
            end else begin
               ans_d    = decNext;
               outSym_d = lut_sym_i;
               outVld_d = 1'b1;
               fsm_d    = OUTPUT;
            end
         end
         OUTPUT: begin
            if (out_rdy_i) begin
               outVld_d    = 1'b0;
               remaining_d = remaining_q - LEN_WIDTH'(1);
               fsm_d       = RENORM;
            end
         end
         RENORM: begin
            // Stay here while below the lower bound; each chunk is re-evaluated next cycle.
            if (ans_q < LBOUND) begin
               if (in_vld_i) begin
                  ans_d = shifted;
               end
            end else if (remaining_q == '0) begin
               done_d = 1'b1;
               fsm_d  = IDLE;
            end else begin
               fsm_d = DECODE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fsm_q       <= IDLE;
         ans_q       <= '0;
         remaining_q <= '0;
         chunkCnt_q  <= '0;
         outSym_q    <= '0;
         outVld_q    <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else if (ena_i) begin
         fsm_q       <= fsm_d;
         ans_q       <= ans_d;
         remaining_q <= remaining_d;
         chunkCnt_q  <= chunkCnt_d;
         outSym_q    <= outSym_d;
         outVld_q    <= outVld_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign in_rdy_o   = inRdy;
   assign lut_slot_o = ans_q[PROB_BITS-1:0];
   assign out_o      = outSym_q;
   assign out_vld_o  = outVld_q;
   assign busy_o     = (fsm_q != IDLE);
   assign done_o     = done_q;
   assign err_o      = err_q;

endmodule

// File: doc/ans_decoder.md
Name: ans_decoder

Overview:
rANS decoder, the receive-side counterpart of the team's ans_encoder. Consumes the SYM_WIDTH-bit chunk stream produced by the encoder and loads the initial state from the first chunks. Recovers symbols through an external frequency table (slot -> symbol/count/cumulative) and emits them on a valid/ready output. Sits between the compressed-byte input port and the symbol sink.

Parameters:
SYM_WIDTH, 8, width of input chunks and output symbols
CNT_WIDTH, 9, width of symbol count (must hold 1<<PROB_BITS)
PROB_BITS, 8, log2 of total_count; total_count = 1<<PROB_BITS
STATE_WIDTH, 16, ANS state width; renorm lower bound L = 1<<(STATE_WIDTH-SYM_WIDTH)
LEN_WIDTH, 16, width of symbol-count-to-decode

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
ena  in  1  clock enable; when low, all registers hold
start  in  1  begin a block; sampled only in IDLE
num_syms  in  LEN_WIDTH  symbols to decode, latched on start
in_data  in  SYM_WIDTH  compressed chunk
in_vld  in  1  in_data valid
in_rdy  out  1  decoder accepts chunk
lut_slot  out  PROB_BITS  state mod total_count, valid whenever in DECODE
lut_sym  in  SYM_WIDTH  symbol owning lut_slot (combinational table)
lut_count  in  CNT_WIDTH  count of lut_sym
lut_cum  in  CNT_WIDTH  cumulative count of lut_sym
out  out  SYM_WIDTH  decoded symbol
out_vld  out  1  out valid
out_rdy  in  1  sink accepts out
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when block complete
err  out  1  sticky until rst/start; lut_count==0 or lut_cum+lut_count > total_count in DECODE

Behaviour:
- Reset (rst=1 at clk edge, overrides ena): state_reg=0, remaining=0, FSM=IDLE, in_rdy=0, out=0, out_vld=0, done=0, err=0.
- All transfers happen on a clk edge with ena=1 and vld&rdy both high.
- FSM states: IDLE, INIT, DECODE, OUTPUT, RENORM.
- IDLE: start=1 -> latch num_syms into remaining, clear err, chunk_cnt=0, go INIT; start=1 with num_syms=0 -> done pulse next cycle, stay IDLE.
- INIT: in_rdy=1; each accepted chunk: state_reg = (state_reg<<SYM_WIDTH)|in_data (MSB chunk first); after STATE_WIDTH/SYM_WIDTH chunks -> DECODE, in_rdy=0.
- DECODE (1 cycle): lut_slot = state_reg[PROB_BITS-1:0]; next state = lut_count*(state_reg>>PROB_BITS) + lut_slot - lut_cum, computed at STATE_WIDTH+1 bits then truncated; out<=lut_sym, out_vld<=1, -> OUTPUT. On err condition: err<=1, state_reg unchanged, out_vld stays 0, -> IDLE, done pulse.
- OUTPUT: hold out/out_vld stable until out_rdy; on handshake out_vld<=0, remaining-=1, -> RENORM.
- RENORM: if state_reg < L: in_rdy=1, each chunk shifts in as in INIT; re-evaluate next cycle. When state_reg >= L: in_rdy=0; remaining==0 -> done pulse, IDLE; else -> DECODE.
- Latency: first symbol out_vld asserts 1 cycle after DECODE entry; min 3 cycles per symbol when no renorm is needed.
- in_rdy never high in IDLE, DECODE or OUTPUT; out_vld never high outside OUTPUT.
- ena=0 mid-operation freezes everything including out_vld; start ignored when not IDLE.
- rst mid-block: immediate return to reset values; partial symbol/chunk dropped.

Test Plan:
- Reset: rst high 2 cycles mid-RENORM -> next cycle in_rdy=0, out_vld=0, busy=0, done=0, err=0.
- Single symbol: table slot<128 -> A(0x41,count 128,cum 0), else B(0x42,count 128,cum 128); start num_syms=1, chunks 0x01,0x00 -> out=0x41; state 256->128; RENORM takes chunk 0x5A -> state 0x805A; done pulse.
- Stream: same table, num_syms=4, chunks from a reference rANS encoding of "ABBA" -> out sequence 0x41,0x42,0x42,0x41, exactly all supplied chunks consumed, done once.
- Backpressure: out_rdy low 5 cycles in OUTPUT -> out/out_vld stable, no chunk consumed, remaining unchanged.
- Error: table returns lut_count=0 -> err=1, no out_vld, done pulse, IDLE; next start clears err.
- ena gating: ena low 3 cycles during INIT with in_vld high -> no chunk accepted, state_reg unchanged.
